// File: rtl/floo_tile_link_buffer.sv
// floo_tile_link_buffer: per-port elastic flit buffer at the tile/NoC edge with a
// RUN/DRAIN/ISOLATED quiesce FSM.
// Optional feature macro: FLOO_TILE_LINK_PERF_EN (per-port output handshake counters).
module floo_tile_link_buffer #(
    parameter int unsigned NumPorts     = 4,
    parameter int unsigned FlitWidth    = 64,
    parameter int unsigned Depth        = 4,
    parameter int unsigned DrainTimeout = 256
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumPorts-1:0]           in_valid_i,
    output logic [NumPorts-1:0]           in_ready_o,
    input  logic [NumPorts*FlitWidth-1:0] in_data_i,
    output logic [NumPorts-1:0]           out_valid_o,
    input  logic [NumPorts-1:0]           out_ready_i,
    output logic [NumPorts*FlitWidth-1:0] out_data_o,
    input  logic                          isolate_i,
    output logic                          isolated_o,
    output logic                          drain_timeout_o,
    input  logic                          perf_clr_i,
    output logic [NumPorts*32-1:0]        perf_cnt_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam int unsigned DtoW = $clog2(DrainTimeout + 1);

    localparam logic [CntW-1:0] CntFull = CntW'(Depth);
    localparam logic [DtoW-1:0] DtoSat  = DtoW'(DrainTimeout);
    localparam logic [DtoW-1:0] DtoFire = DtoW'(DrainTimeout - 1);

    typedef enum logic [1:0] {
        StRun,
        StDrain,
        StIsolated
    } state_e;

    state_e state_q, state_d;

    logic [FlitWidth-1:0] mem_q    [NumPorts][Depth];
    logic [FlitWidth-1:0] mem_d    [NumPorts][Depth];
    logic [PtrW-1:0]      wr_ptr_q [NumPorts];
    logic [PtrW-1:0]      wr_ptr_d [NumPorts];
    logic [PtrW-1:0]      rd_ptr_q [NumPorts];
    logic [PtrW-1:0]      rd_ptr_d [NumPorts];
    logic [CntW-1:0]      cnt_q    [NumPorts];
    logic [CntW-1:0]      cnt_d    [NumPorts];

    logic [DtoW-1:0]      drain_cnt_q, drain_cnt_d;
    logic                 timeout_q, timeout_d;

    logic [NumPorts-1:0]  push;
    logic [NumPorts-1:0]  pop;
    logic                 all_empty;

    // Link-side handshake signals; everything is gated off while reset is held.
    always_comb begin
        for (int p = 0; p < NumPorts; p++) begin
            in_ready_o[p]  = !rst_i && (state_q == StRun) && (cnt_q[p] != CntFull);
            out_valid_o[p] = !rst_i && (cnt_q[p] != '0) && (state_q != StIsolated);
            out_data_o[p*FlitWidth +: FlitWidth] = mem_q[p][rd_ptr_q[p]];
        end
    end

    assign push = in_valid_i & in_ready_o;
    assign pop  = out_valid_o & out_ready_i;

    // FIFO next state: write at tail, read from head, occupancy tracks push/pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        for (int p = 0; p < NumPorts; p++) begin
            if (push[p]) begin
                mem_d[p][wr_ptr_q[p]] = in_data_i[p*FlitWidth +: FlitWidth];
                wr_ptr_d[p]           = wr_ptr_q[p] + PtrW'(1);
            end
            if (pop[p]) begin
                rd_ptr_d[p] = rd_ptr_q[p] + PtrW'(1);
            end
            case ({push[p], pop[p]})
                2'b10:   cnt_d[p] = cnt_q[p] + CntW'(1);
                2'b01:   cnt_d[p] = cnt_q[p] - CntW'(1);
                default: cnt_d[p] = cnt_q[p];
            endcase
        end
    end

    // Empty check uses post-pop occupancy so the final pop can complete the drain.
    always_comb begin
        all_empty = 1'b1;
        for (int p = 0; p < NumPorts; p++) begin
            if (cnt_d[p] != '0) begin
                all_empty = 1'b0;
            end
        end
    end

    // Quiesce FSM next state, drain-cycle counter and timeout pulse.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (isolate_i) state_d = StDrain;
            end
            StDrain: begin
                if (!isolate_i)     state_d = StRun;
                else if (all_empty) state_d = StIsolated;
            end
            StIsolated: begin
                if (!isolate_i) state_d = StRun;
            end
            default: state_d = StRun;
        endcase

        // Counter holds the number of completed DRAIN cycles; it saturates one past the
        // firing value so the pulse cannot repeat.
        drain_cnt_d = '0;
        timeout_d   = 1'b0;
        if ((state_q == StDrain) && (state_d == StDrain)) begin
            drain_cnt_d = (drain_cnt_q == DtoSat) ? drain_cnt_q : drain_cnt_q + DtoW'(1);
            timeout_d   = (drain_cnt_q == DtoFire);
        end
    end

    assign isolated_o      = !rst_i && (state_q == StIsolated);
    assign drain_timeout_o = !rst_i && timeout_q;

    // Flit storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    // Control state with synchronous reset; reset discards any buffered flits.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int p = 0; p < NumPorts; p++) begin
                wr_ptr_q[p] <= '0;
                rd_ptr_q[p] <= '0;
                cnt_q[p]    <= '0;
            end
            state_q     <= StRun;
            drain_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

`ifdef FLOO_TILE_LINK_PERF_EN
    logic [31:0] perf_q [NumPorts];
    logic [31:0] perf_d [NumPorts];

    // Saturating output-handshake counters; clear takes priority over counting.
    always_comb begin
        perf_d = perf_q;
        for (int p = 0; p < NumPorts; p++) begin
            if (perf_clr_i) begin
                perf_d[p] = '0;
            end else if (pop[p] && (perf_q[p] != 32'hFFFF_FFFF)) begin
                perf_d[p] = perf_q[p] + 32'd1;
            end
        end
    end

    // Pack counters onto the flat output bus.
    always_comb begin
        for (int p = 0; p < NumPorts; p++) begin
            perf_cnt_o[p*32 +: 32] = perf_q[p];
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int p = 0; p < NumPorts; p++) begin
                perf_q[p] <= '0;
            end
        end else begin
            perf_q <= perf_d;
        end
    end
`else
    logic unused_perf_clr;

    assign unused_perf_clr = perf_clr_i;
    assign perf_cnt_o      = '0;
`endif

endmodule

// File: tb/tb_floo_tile_link_buffer.sv
// Scoreboard bench for floo_tile_link_buffer: per-port flit queues plus a mode-level model
// of the quiesce behaviour, checked every cycle on the falling clock edge.
module tb_floo_tile_link_buffer;

    localparam int NP    = 4;
    localparam int FW    = 64;
    localparam int DEPTH = 4;
    localparam int DTO   = 8;

    localparam int MRun  = 0;
    localparam int MDrn  = 1;
    localparam int MIso  = 2;

    logic              clk;
    logic              rst;
    logic [NP-1:0]     in_valid;
    logic [NP-1:0]     in_ready;
    logic [NP*FW-1:0]  in_data;
    logic [NP-1:0]     out_valid;
    logic [NP-1:0]     out_ready;
    logic [NP*FW-1:0]  out_data;
    logic              isolate;
    logic              isolated;
    logic              drain_timeout;
    logic              perf_clr;
    logic [NP*32-1:0]  perf_cnt;

    floo_tile_link_buffer #(
        .NumPorts    (NP),
        .FlitWidth   (FW),
        .Depth       (DEPTH),
        .DrainTimeout(DTO)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .in_data_i      (in_data),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .out_data_o     (out_data),
        .isolate_i      (isolate),
        .isolated_o     (isolated),
        .drain_timeout_o(drain_timeout),
        .perf_clr_i     (perf_clr),
        .perf_cnt_o     (perf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef logic [FW-1:0] flit_q_t[$];

    flit_q_t     sb_q [NP];
    int          mode;
    int          drain_cycles;
    logic [31:0] perf_m [NP];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: compare this cycle's outputs, then advance on the coming edge.
    always @(negedge clk) begin : model
        logic [NP-1:0]    e_ready;
        logic [NP-1:0]    e_valid;
        logic [NP*32-1:0] e_perf;
        bit               empty;
        if (rst) begin
            check("rst_in_ready", in_ready, '0);
            check("rst_out_valid", out_valid, '0);
            check("rst_isolated", isolated, 1'b0);
            check("rst_timeout", drain_timeout, 1'b0);
            for (int p = 0; p < NP; p++) begin
                sb_q[p].delete();
                perf_m[p] = '0;
            end
            mode         = MRun;
            drain_cycles = 0;
        end else begin
            for (int p = 0; p < NP; p++) begin
                e_ready[p] = (mode == MRun) && (sb_q[p].size() < DEPTH);
                e_valid[p] = (sb_q[p].size() != 0) && (mode != MIso);
                e_perf[p*32 +: 32] = perf_m[p];
            end
            check("in_ready", in_ready, e_ready);
            check("out_valid", out_valid, e_valid);
            check("isolated", isolated, mode == MIso);
            check("drain_timeout", drain_timeout, (mode == MDrn) && (drain_cycles == DTO));
            check("perf_cnt", perf_cnt, e_perf);
            for (int p = 0; p < NP; p++) begin
                if (e_valid[p]) begin
                    check($sformatf("out_data[%0d]", p), out_data[p*FW +: FW], sb_q[p][0]);
                end
            end
            // Advance: pops, pushes, counters, mode.
            for (int p = 0; p < NP; p++) begin
                if (e_valid[p] && out_ready[p]) begin
                    void'(sb_q[p].pop_front());
`ifdef FLOO_TILE_LINK_PERF_EN
                    if (perf_m[p] != 32'hFFFF_FFFF) perf_m[p] = perf_m[p] + 1;
`endif
                end
                if (e_ready[p] && in_valid[p]) begin
                    sb_q[p].push_back(in_data[p*FW +: FW]);
                end
                if (perf_clr) perf_m[p] = '0;
            end
            empty = 1'b1;
            for (int p = 0; p < NP; p++) begin
                if (sb_q[p].size() != 0) empty = 1'b0;
            end
            case (mode)
                MRun: begin
                    if (isolate) begin
                        mode         = MDrn;
                        drain_cycles = 0;
                    end
                end
                MDrn: begin
                    if (!isolate)   mode = MRun;
                    else if (empty) mode = MIso;
                    else            drain_cycles++;
                end
                default: begin
                    if (!isolate) mode = MRun;
                end
            endcase
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        for (int p = 0; p < NP; p++) begin
            in_data[p*FW +: FW] = {$urandom(), $urandom()};
        end
    endtask

    initial begin : stim
        int waited;
        int pulses;
        rst       = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        out_ready = '0;
        isolate   = 1'b0;
        perf_clr  = 1'b0;
        step(3);
        rst = 1'b0;
        step(1);

        // Single flit on port 2 appears the following cycle.
        out_ready = '1;
        in_valid  = 4'b0100;
        in_data[2*FW +: FW] = 64'hA5;
        step(1);
        in_valid = '0;
        check("t1_valid", out_valid, 4'b0100);
        check("t1_data", out_data[2*FW +: FW], 64'hA5);
        step(2);

        // Five offers into a stalled port 0: only Depth accepted.
        out_ready = '0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 4'b0001;
            in_data[FW-1:0] = 64'(i + 1);
            step(1);
        end
        in_valid = '0;
        check("t2_full_ready", in_ready[0], 1'b0);
        out_ready = '1;
        step(6);

        // Random traffic, no isolation.
        for (int i = 0; i < 300; i++) begin
            in_valid  = NP'($urandom());
            out_ready = NP'($urandom());
            rand_data();
            step(1);
        end
        in_valid  = '0;
        out_ready = '1;
        step(DEPTH + 1);

        // Fill port 1 then quiesce with the sink ready.
        out_ready = '0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 4'b0010;
            rand_data();
            step(1);
        end
        in_valid  = '0;
        isolate   = 1'b1;
        out_ready = '1;
        waited    = 0;
        while (!isolated && waited < 20) begin
            step(1);
            waited++;
        end
        check("t3_isolated_reached", isolated, 1'b1);
        step(2);
        isolate = 1'b0;
        step(1);
        check("t3_released", {isolated, in_ready}, {1'b0, 4'hF});

        // Stalled drain: exactly one timeout pulse, never isolated.
        out_ready = '0;
        in_valid  = 4'b0001;
        rand_data();
        step(1);
        in_valid = '0;
        isolate  = 1'b1;
        pulses   = 0;
        for (int i = 0; i < 2 * DTO; i++) begin
            step(1);
            if (drain_timeout) pulses++;
        end
        check("t4_pulse_count", pulses, 1);
        check("t4_not_isolated", isolated, 1'b0);
        isolate   = 1'b0;
        out_ready = '1;
        step(4);

        // Performance counters on port 3.
        perf_clr = 1'b1;
        step(1);
        perf_clr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 4'b1000;
            rand_data();
            step(1);
        end
        in_valid = '0;
        step(3);
`ifdef FLOO_TILE_LINK_PERF_EN
        check("t5_perf", perf_cnt, {32'd10, 32'd0, 32'd0, 32'd0});
`else
        check("t5_perf", perf_cnt, '0);
`endif
        perf_clr = 1'b1;
        step(1);
        perf_clr = 1'b0;
        step(1);
        check("t5_perf_clr", perf_cnt, '0);

        // Random traffic with isolation toggling and sparse counter clears.
        for (int i = 0; i < 600; i++) begin
            in_valid  = NP'($urandom());
            out_ready = NP'($urandom() & $urandom());
            rand_data();
            if ($urandom_range(19) == 0) isolate = ~isolate;
            perf_clr = ($urandom_range(49) == 0);
            step(1);
        end
        isolate   = 1'b0;
        perf_clr  = 1'b0;
        in_valid  = '0;
        out_ready = '1;
        step(DEPTH + 2);

        // Reset in the middle of a drain discards buffered flits.
        out_ready = '0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 4'b0011;
            rand_data();
            step(1);
        end
        in_valid = '0;
        isolate  = 1'b1;
        step(2);
        rst = 1'b1;
        step(1);
        rst     = 1'b0;
        isolate = 1'b0;
        #1;
        check("t6_valid_after_rst", out_valid, '0);
        check("t6_run_after_rst", in_ready, 4'hF);
        out_ready = '1;
        step(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
